// File: rtl/sys_defs.sv
// Shared type definitions for the completion stage: functional-unit results and CDB packets.
package sys_defs;

  localparam int unsigned NUM_FU_DEFAULT  = 4;
  localparam int unsigned NUM_CDB_DEFAULT = 2;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned PRF_IDX_W       = 6;
  localparam int unsigned ROB_IDX_W       = 5;
  // Wide enough for up to 16 functional units.
  localparam int unsigned FU_IDX_W        = 4;

  typedef struct packed {
    logic                 valid;
    logic [PRF_IDX_W-1:0] dest_prf;
    logic [XLEN-1:0]      value;
    logic                 value_valid;
    logic [ROB_IDX_W-1:0] rob_entry;
    logic [XLEN-1:0]      branch_address;
  } FUNC_OUTPUT;

  typedef struct packed {
    logic                 valid;
    logic [PRF_IDX_W-1:0] dest_prf;
    logic [XLEN-1:0]      value;
    logic                 value_valid;
    logic [ROB_IDX_W-1:0] rob_entry;
    logic [XLEN-1:0]      branch_address;
    logic [FU_IDX_W-1:0]  fu_idx;
  } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Multi-grant picker: scans requests starting at base, wrapping modulo NUM_FU, and hands the
// first NUM_CDB hits to slots 0..NUM_CDB-1 in search order.
module rr_picker #(
  parameter int unsigned NUM_FU  = 4,
  parameter int unsigned NUM_CDB = 2,
  localparam int unsigned PW     = $clog2(NUM_FU),
  localparam int unsigned CW     = $clog2(NUM_CDB + 1)
) (
  input  logic [NUM_FU-1:0]           req,
  input  logic [PW-1:0]               base,
  output logic [NUM_CDB-1:0][PW-1:0]  grant_idx,
  output logic [NUM_CDB-1:0]          grant_vld,
  output logic [NUM_FU-1:0]           grant_mask
);

  always_comb begin
    logic [CW-1:0] cnt;
    logic [PW:0]   pos;
    logic [PW-1:0] idx;
    grant_idx  = '0;
    grant_vld  = '0;
    grant_mask = '0;
    cnt        = '0;
    pos        = '0;
    idx        = '0;
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      // Explicit modulo wrap so non-power-of-two unit counts work.
      pos = {1'b0, base} + (PW+1)'(off);
      if (pos >= (PW+1)'(NUM_FU)) pos = pos - (PW+1)'(NUM_FU);
      idx = pos[PW-1:0];
      if (req[idx] && (cnt < CW'(NUM_CDB))) begin
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
          if (cnt == CW'(k)) begin
            grant_idx[k] = idx;
            grant_vld[k] = 1'b1;
          end
        end
        grant_mask[idx] = 1'b1;
        cnt = cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion-stage arbiter: grants up to NUM_CDB functional-unit results per cycle onto the CDB.
// Define CDB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index always wins.
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int unsigned NUM_FU  = NUM_FU_DEFAULT,
  parameter int unsigned NUM_CDB = NUM_CDB_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  FUNC_OUTPUT [NUM_FU-1:0]  fu_out,
  input  logic                     cdb_stall,
  input  logic                     flush,
  output logic [NUM_FU-1:0]        sel,
  output CDB_PACKET [NUM_CDB-1:0]  cdb
);

  localparam int unsigned PW = $clog2(NUM_FU);

  logic [NUM_FU-1:0]          req;
  logic [NUM_FU-1:0]          grant_mask;
  logic [NUM_CDB-1:0][PW-1:0] grant_idx;
  logic [NUM_CDB-1:0]         grant_vld;
  logic [PW-1:0]              base;
  CDB_PACKET [NUM_CDB-1:0]    cdb_d;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) req[i] = fu_out[i].valid;
  end

  rr_picker #(
    .NUM_FU  (NUM_FU),
    .NUM_CDB (NUM_CDB)
  ) u_picker (
    .req        (req),
    .base       (base),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld),
    .grant_mask (grant_mask)
  );

`ifdef CDB_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_ptr_d;

  assign base = rr_ptr;

  always_comb begin
    rr_ptr_d = rr_ptr;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (grant_vld[k]) begin
        rr_ptr_d = (grant_idx[k] == PW'(NUM_FU - 1)) ? '0 : grant_idx[k] + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (!flush && !cdb_stall) begin
      rr_ptr <= rr_ptr_d;
    end
  end
`else
  assign base = '0;
`endif

  // Units only drop their result when the edge will actually capture it.
  assign sel = (!reset || cdb_stall || flush) ? '0 : grant_mask;

  always_comb begin
    cdb_d = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (grant_vld[k]) begin
        cdb_d[k].valid          = 1'b1;
        cdb_d[k].dest_prf       = fu_out[grant_idx[k]].dest_prf;
        cdb_d[k].value          = fu_out[grant_idx[k]].value;
        cdb_d[k].value_valid    = fu_out[grant_idx[k]].value_valid;
        cdb_d[k].rob_entry      = fu_out[grant_idx[k]].rob_entry;
        cdb_d[k].branch_address = fu_out[grant_idx[k]].branch_address;
        cdb_d[k].fu_idx         = FU_IDX_W'(grant_idx[k]);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb <= '0;
    end else if (flush) begin
      for (int unsigned k = 0; k < NUM_CDB; k++) cdb[k].valid <= 1'b0;
    end else if (!cdb_stall) begin
      cdb <= cdb_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations follow CDB_ROUND_ROBIN_EN when it is defined.
module tb_cdb_arbiter;
  import sys_defs::*;

`ifdef CDB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             cdb_stall;
  logic             flush;
  FUNC_OUTPUT [3:0] fu_out;
  FUNC_OUTPUT [3:0] fu_out1;
  logic [3:0]       sel;
  logic [3:0]       sel1;
  CDB_PACKET [1:0]  cdb;
  CDB_PACKET [0:0]  cdb1;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(
    .NUM_FU  (4),
    .NUM_CDB (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .fu_out    (fu_out),
    .cdb_stall (cdb_stall),
    .flush     (flush),
    .sel       (sel),
    .cdb       (cdb)
  );

  cdb_arbiter #(
    .NUM_FU  (4),
    .NUM_CDB (1)
  ) dut1 (
    .clock     (clock),
    .reset     (reset),
    .fu_out    (fu_out1),
    .cdb_stall (cdb_stall),
    .flush     (flush),
    .sel       (sel1),
    .cdb       (cdb1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic [0:0] k, input logic v,
                          input logic [31:0] val, input logic [3:0] idx);
    check({tag, ".valid"}, 32'(cdb[k].valid), 32'(v));
    if (v) begin
      check({tag, ".value"}, cdb[k].value, val);
      check({tag, ".fu_idx"}, 32'(cdb[k].fu_idx), 32'(idx));
    end
  endtask

  task automatic set_fu(input logic [1:0] i, input logic v, input logic [31:0] val);
    fu_out[i].valid          = v;
    fu_out[i].value          = val;
    fu_out[i].dest_prf       = 6'(i) + 6'd8;
    fu_out[i].value_valid    = 1'b1;
    fu_out[i].rob_entry      = 5'(i) + 5'd3;
    fu_out[i].branch_address = 32'h400 + 32'(i);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    cdb_stall = 1'b0;
    flush     = 1'b0;
    fu_out    = '0;
    fu_out1   = '0;
    #2;
    check("reset.sel", 32'(sel), 32'h0);
    chk_slot("reset.cdb0", 1'b0, 1'b0, 32'h0, 4'd0);
    chk_slot("reset.cdb1", 1'b1, 1'b0, 32'h0, 4'd0);
    step();
    reset = 1'b1;
    step();

    // Contention, all four held valid
    for (int i = 0; i < 4; i++) set_fu(2'(i), 1'b1, 32'h100 + 32'(i));
    #1;
    check("cont.sel1", 32'(sel), 32'h3);
    check("cont.dest_prf", 32'(fu_out[1].dest_prf), 32'd9);
    step();
    chk_slot("cont.c1.cdb0", 1'b0, 1'b1, 32'h100, 4'd0);
    chk_slot("cont.c1.cdb1", 1'b1, 1'b1, 32'h101, 4'd1);
    check("cont.c1.rob", 32'(cdb[1].rob_entry), 32'd4);
    check("cont.sel2", 32'(sel), RR ? 32'hC : 32'h3);
    step();
    chk_slot("cont.c2.cdb0", 1'b0, 1'b1, RR ? 32'h102 : 32'h100, RR ? 4'd2 : 4'd0);
    chk_slot("cont.c2.cdb1", 1'b1, 1'b1, RR ? 32'h103 : 32'h101, RR ? 4'd3 : 4'd1);
    check("cont.sel3_wrap", 32'(sel), 32'h3);
    fu_out = '0;
    step();
    chk_slot("idle.cdb0", 1'b0, 1'b0, 32'h0, 4'd0);
    chk_slot("idle.cdb1", 1'b1, 1'b0, 32'h0, 4'd0);

    // Single result
    set_fu(2'd2, 1'b1, 32'h1234);
    #1;
    check("single.sel", 32'(sel), 32'h4);
    step();
    set_fu(2'd2, 1'b0, 32'h1234);
    chk_slot("single.cdb0", 1'b0, 1'b1, 32'h1234, 4'd2);
    chk_slot("single.cdb1", 1'b1, 1'b0, 32'h0, 4'd0);

    // Stall for three cycles with two units pending
    cdb_stall = 1'b1;
    set_fu(2'd0, 1'b1, 32'hA0);
    set_fu(2'd1, 1'b1, 32'hA1);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall.sel", 32'(sel), 32'h0);
      step();
      chk_slot("stall.cdb0", 1'b0, 1'b1, 32'h1234, 4'd2);
    end
    cdb_stall = 1'b0;
    #1;
    check("unstall.sel", 32'(sel), 32'h3);
    step();
    fu_out = '0;
    chk_slot("unstall.cdb0", 1'b0, 1'b1, 32'hA0, 4'd0);
    chk_slot("unstall.cdb1", 1'b1, 1'b1, 32'hA1, 4'd1);

    // Flush together with stall kills broadcasts and leaves the pointer alone
    flush     = 1'b1;
    cdb_stall = 1'b1;
    set_fu(2'd3, 1'b1, 32'hB3);
    #1;
    check("flush.sel", 32'(sel), 32'h0);
    step();
    chk_slot("flush.cdb0", 1'b0, 1'b0, 32'h0, 4'd0);
    chk_slot("flush.cdb1", 1'b1, 1'b0, 32'h0, 4'd0);
    flush     = 1'b0;
    cdb_stall = 1'b0;
    set_fu(2'd0, 1'b1, 32'hB0);
    #1;
    check("postflush.sel", 32'(sel), 32'h9);
    step();
    fu_out = '0;
    chk_slot("postflush.cdb0", 1'b0, 1'b1, RR ? 32'hB3 : 32'hB0, RR ? 4'd3 : 4'd0);
    chk_slot("postflush.cdb1", 1'b1, 1'b1, RR ? 32'hB0 : 32'hB3, RR ? 4'd0 : 4'd3);

    // Asynchronous reset in the middle of a broadcast
    set_fu(2'd1, 1'b1, 32'hC1);
    #2;
    reset = 1'b0;
    #1;
    check("areset.sel", 32'(sel), 32'h0);
    chk_slot("areset.cdb0", 1'b0, 1'b0, 32'h0, 4'd0);
    chk_slot("areset.cdb1", 1'b1, 1'b0, 32'h0, 4'd0);
    fu_out = '0;
    step();
    reset = 1'b1;
    set_fu(2'd0, 1'b1, 32'hD0);
    set_fu(2'd3, 1'b1, 32'hD3);
    step();
    fu_out = '0;
    chk_slot("rst_rel.cdb0", 1'b0, 1'b1, 32'hD0, 4'd0);
    chk_slot("rst_rel.cdb1", 1'b1, 1'b1, 32'hD3, 4'd3);

    // Fairness with a single CDB slot, units 0 and 3 held valid
    fu_out1[0].valid = 1'b1;
    fu_out1[0].value = 32'hE0;
    fu_out1[3].valid = 1'b1;
    fu_out1[3].value = 32'hE3;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("fair.sel", 32'(sel1),
            (RR && (c % 2 == 1)) ? 32'h8 : 32'h1);
      step();
      check("fair.cdb_idx", 32'(cdb1[0].fu_idx),
            (RR && (c % 2 == 1)) ? 32'd3 : 32'd0);
      check("fair.cdb_valid", 32'(cdb1[0].valid), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-stage arbiter between the functional units and the common data bus (CDB). Each cycle it picks up to NUM_CDB valid FUNC_OUTPUT results from NUM_FU functional units, returns a one-hot-per-grant `sel` to each chosen unit so the unit drops its result, and registers the chosen results onto the CDB for the ROB, reservation stations and map table. Arbitration is round-robin to prevent starvation; a flush kills in-flight broadcasts.

## Interface
- NUM_FU, 4: number of functional-unit result ports (≥2).
- NUM_CDB, 2: CDB broadcast slots per cycle (1 ≤ NUM_CDB ≤ NUM_FU).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- fu_out  in  NUM_FU × FUNC_OUTPUT  per-unit results; `.valid` marks a pending result.
- cdb_stall  in  1  downstream cannot accept a broadcast this cycle.
- flush  in  1  branch mispredict squash.
- sel  out  NUM_FU  sel[i]=1: unit i's result is captured at this clock edge.
- cdb  out  NUM_CDB × CDB_PACKET  registered broadcasts (valid, dest_prf, value, value_valid, rob_entry, branch_address, fu_idx).

## Operation
- Combinational grant: starting at index rr_ptr and wrapping modulo NUM_FU, take the first NUM_CDB units with fu_out[i].valid=1. k-th grant goes to cdb slot k (search order); unused slots load valid=0.
- sel[i]=1 exactly for granted units; sel is all-zero when cdb_stall=1 or flush=1.
- On a clock edge with grants issued: cdb[k] <= packet built from granted fu_out; fu_idx = granted index; rr_ptr <= (last granted index + 1) mod NUM_FU.
- No grants (no valid inputs): cdb slots load valid=0, rr_ptr unchanged.
- cdb_stall=1, flush=0: cdb registers and rr_ptr hold; no sel.
- flush=1: all cdb[k].valid <= 0, rr_ptr holds, no sel; flush wins over cdb_stall.
- Fields other than valid are copied as-is; value_valid=0 packets (stores, x0 destinations) still occupy a slot.
- Reset (reset=0, any time, asynchronous): all cdb slots cleared to 0 (valid=0), rr_ptr=0; sel is 0 while reset is asserted.

## Timing
- Unit result valid in cycle t, granted → sel[i]=1 in cycle t; cdb valid in t+1; unit's valid falls in t+1.
- Latency fu_out → cdb: 1 cycle. Throughput: NUM_CDB results/cycle.
- A unit that is not granted keeps its valid; it is reconsidered next cycle with no loss.
- Worst-case wait for any valid unit under round-robin: ceil(NUM_FU/NUM_CDB) − 1 cycles with no stall.
- Stall lasting n cycles holds cdb contents n cycles; broadcasts are not repeated as new grants.
- rr_ptr width: $clog2(NUM_FU); wrap from NUM_FU−1 to 0 is explicit, not power-of-two dependent.

## Configuration
- CDB_ROUND_ROBIN_EN defined: rotating priority as above.
- Undefined: fixed priority, search always starts at index 0 (lowest index wins); rr_ptr removed. Everything else identical.

## Structure
- Shared package (sys_defs): FUNC_OUTPUT, CDB_PACKET, NUM_FU, NUM_CDB defaults, PRF/ROB index widths.
- One sub-module: rr_picker — given request vector, base pointer and NUM_CDB, returns per-slot grant indices/valids and a grant mask. Arbiter top holds registers and packet muxing.

## Test plan
- Reset: drive reset=0 mid-broadcast with cdb[0].valid=1 → cdb all valid=0 immediately, sel=0; after release first grant starts from index 0.
- Single result: fu_out[2].valid=1, value=0x1234 → sel=4'b0100 same cycle; next cycle cdb[0]={valid 1, value 0x1234, fu_idx 2}, cdb[1].valid=0.
- Contention, NUM_FU=4, NUM_CDB=2, all four valid and held: cycle 1 grants 0,1 (sel=0011), cycle 2 grants 2,3 (sel=1100), rr_ptr wraps to 0.
- Fairness: units 0 and 3 valid continuously, NUM_CDB=1 → grants alternate 0,3,0,3; with macro undefined unit 0 wins every cycle.
- Stall: cdb holds 3 cycles with cdb_stall=1, sel=0 throughout; pending units keep valid and are granted the cycle stall drops.
- Flush with stall: flush=1 and cdb_stall=1 together with cdb valid → next cycle all cdb valid=0, sel=0, rr_ptr unchanged.
